// File: rtl/div_mse_monitor_if.sv
// Sample channel from the approximate divider into the MSE monitor:
// operand pair plus the approximate quotient/remainder, valid/ready handshake.
interface div_mse_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n;
  logic [7:0]  d;
  logic [7:0]  q_apx;
  logic [7:0]  r_apx;

  modport master (output in_valid, n, d, q_apx, r_apx, input in_ready);
  modport slave  (input in_valid, n, d, q_apx, r_apx, output in_ready);
endinterface

// File: rtl/div_mse_monitor.sv
// Error monitor for the 16/8 approximate divider: recomputes the exact result with a
// bit-serial restoring divider and accumulates squared/max quotient error and remainder mismatches.
module div_mse_monitor #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  div_mse_monitor_if.slave smp,
  output logic             res_valid,
  output logic             busy,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] oor_cnt,
  output logic [CNT_W-1:0] r_mis_cnt,
  output logic [7:0]       max_abs_err,
  output logic             acc_sat
);

  localparam int unsigned ACC_XW = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0] n_lo;
  logic [7:0] d_r;
  logic [7:0] q_apx_r;
  logic [7:0] r_apx_r;
  logic [7:0] rem;
  logic [7:0] q_ex;
  logic [2:0] iter;

  logic             accept_c;
  logic             oor_c;
  logic [8:0]       shifted;
  logic [8:0]       sub;
  logic             take;
  logic [7:0]       rem_nxt;
  logic [8:0]       err;
  logic [7:0]       abs_err;
  logic [15:0]      sq;
  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign smp.in_ready = (state == IDLE) && !clear;
  assign busy         = (state != IDLE);
  assign accept_c     = smp.in_valid && smp.in_ready;
  // The quotient only fits 8 bits when the dividend's upper byte is below the divisor.
  assign oor_c        = (smp.d == 8'd0) || (smp.n[15:8] >= smp.d);

  // One restoring-division step and the error terms used on the ACC edge
  always_comb begin
    shifted = {rem, n_lo[7]};
    sub     = shifted - {1'b0, d_r};
    take    = (shifted >= {1'b0, d_r});
    rem_nxt = take ? 8'(sub) : 8'(shifted);
    err     = {1'b0, q_apx_r} - {1'b0, q_ex};
    abs_err = err[8] ? 8'(-err) : err[7:0];
    sq      = 16'(abs_err) * 16'(abs_err);
    sum_ext = {1'b0, sum_sq_err} + ACC_XW'(sq);
    sum_ovf = sum_ext[ACC_W];
    sum_nxt = sum_ovf ? '1 : sum_ext[ACC_W-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear aborts any in-flight sample
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c && !oor_c) state_nxt = DIV;
      DIV:     if (iter == 3'd7) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Sample capture and bit-serial exact division
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lo    <= '0;
      d_r     <= '0;
      q_apx_r <= '0;
      r_apx_r <= '0;
      rem     <= '0;
      q_ex    <= '0;
      iter    <= '0;
    end else if (state == IDLE) begin
      if (accept_c && !oor_c) begin
        n_lo    <= smp.n[7:0];
        d_r     <= smp.d;
        q_apx_r <= smp.q_apx;
        r_apx_r <= smp.r_apx;
        rem     <= smp.n[15:8];
        q_ex    <= '0;
        iter    <= '0;
      end
    end else if (state == DIV) begin
      rem  <= rem_nxt;
      n_lo <= {n_lo[6:0], 1'b0};
      q_ex <= {q_ex[6:0], take};
      iter <= iter + 3'd1;
    end
  end

  // Statistics; clear wins over any update in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      sum_sq_err  <= '0;
      sample_cnt  <= '0;
      oor_cnt     <= '0;
      r_mis_cnt   <= '0;
      max_abs_err <= '0;
      acc_sat     <= 1'b0;
    end else if (clear) begin
      res_valid   <= 1'b0;
      sum_sq_err  <= '0;
      sample_cnt  <= '0;
      oor_cnt     <= '0;
      r_mis_cnt   <= '0;
      max_abs_err <= '0;
      acc_sat     <= 1'b0;
    end else begin
      res_valid <= (state == ACC);
      if (accept_c && oor_c) oor_cnt <= sat_inc(oor_cnt);
      if (state == ACC) begin
        sum_sq_err <= sum_nxt;
        if (sum_ovf) acc_sat <= 1'b1;
        sample_cnt <= sat_inc(sample_cnt);
        if (r_apx_r != rem) r_mis_cnt <= sat_inc(r_mis_cnt);
        if (abs_err > max_abs_err) max_abs_err <= abs_err;
      end
    end
  end

endmodule
